// File: rtl/ddr_cmd_decoder_if.sv
// ddr_cmd_decoder_if: DDR4 command/address pin bus plus the decoder's
// classified-command and status outputs.
// The master side (command generator or bench) drives the pins.
// The slave side (ddr_cmd_decoder) drives the decoded results.
// Optional feature macro: CMD_CHECK_EN adds err_pulse/err_count.
//
// Handshake semantics: there is no valid/ready back-pressure on this bus.
// - The pins are sampled on every rising CK_t.
// - cmd_valid is a pure qualifier: it is high for exactly one cycle after
//   the edge that sampled a real command (anything other than DES or NOP).
// - The decoder cannot stall the master.
interface ddr_cmd_decoder_if;
  // command pins
  logic        cs_n;
  logic        act_n;
  logic        RAS_n_A16;
  logic        CAS_n_A15;
  logic        WE_n_A14;
  logic [1:0]  bg_addr;
  logic [1:0]  ba_addr;
  logic        A17;
  logic        A13;
  logic        A12_BC_n;
  logic        A11;
  logic        A10_AP;
  logic [9:0]  A9_A0;
  // decoded outputs
  logic        cmd_valid;
  logic [3:0]  cmd_code;
  logic [3:0]  cmd_bank;
  logic [17:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [2:0]  mr_sel;
  logic [17:0] mr_data;
  logic [4:0]  cur_cl;
  logic [4:0]  cur_cwl;
  logic        cur_bl8;
  logic [15:0] bank_open;
  logic        rd_en;
  logic        wr_en;
  // debug: row-table entry for the bank currently on cmd_bank
  logic [17:0] cur_row;
`ifdef CMD_CHECK_EN
  logic        err_pulse;
  logic [7:0]  err_count;
`endif

  modport master (
    output cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14, bg_addr, ba_addr,
           A17, A13, A12_BC_n, A11, A10_AP, A9_A0,
    input  cmd_valid, cmd_code, cmd_bank, cmd_row, cmd_col, mr_sel, mr_data,
           cur_cl, cur_cwl, cur_bl8, bank_open, rd_en, wr_en, cur_row
`ifdef CMD_CHECK_EN
    , input err_pulse, err_count
`endif
  );

  modport slave (
    input  cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14, bg_addr, ba_addr,
           A17, A13, A12_BC_n, A11, A10_AP, A9_A0,
    output cmd_valid, cmd_code, cmd_bank, cmd_row, cmd_col, mr_sel, mr_data,
           cur_cl, cur_cwl, cur_bl8, bank_open, rd_en, wr_en, cur_row
`ifdef CMD_CHECK_EN
    , output err_pulse, err_count
`endif
  );
endinterface

// File: rtl/ddr_cmd_decoder.sv
// ddr_cmd_decoder: memory-side DDR4 command decoder.
// - Classifies each CK_t cycle into a JEDEC command.
// - Tracks open banks and their rows.
// - Captures CL/CWL/BL from MRS writes.
// - Generates read/write data-window enables.
// Optional feature macro: CMD_CHECK_EN (protocol error pulse and counter).
module ddr_cmd_decoder #(
  parameter int CL_DEFAULT  = 11,
  parameter int CWL_DEFAULT = 9,
  parameter int BL_DEFAULT  = 8
) (
  input  logic               CK_t,
  input  logic               reset_n,
  ddr_cmd_decoder_if.slave   bus
);

  typedef enum logic [3:0] {
    C_DES = 4'd0,  C_NOP = 4'd1,  C_ACT = 4'd2,  C_RD   = 4'd3,
    C_RDA = 4'd4,  C_WR  = 4'd5,  C_WRA = 4'd6,  C_PRE  = 4'd7,
    C_PREA = 4'd8, C_REF = 4'd9,  C_MRS = 4'd10, C_ZQC  = 4'd11,
    C_RFU = 4'd15
  } cmd_e;

  localparam logic [4:0] CL_RST  = 5'(CL_DEFAULT);
  localparam logic [4:0] CWL_RST = 5'(CWL_DEFAULT);
  localparam logic       BL8_RST = (BL_DEFAULT == 8);

  cmd_e        w_cmd;
  logic [3:0]  w_bank;
  logic [17:0] w_addr;
  logic [2:0]  w_mr_sel;
  logic        w_is_rd;
  logic        w_is_wr;
  logic [31:0] w_rd_mask;
  logic [31:0] w_wr_mask;
  logic [15:0] w_bank_open_nxt;
  logic [4:0]  w_cl_nxt;
  logic [4:0]  w_cwl_nxt;
  logic        w_bl8_nxt;

  cmd_e        r_cmd_code;
  logic        r_cmd_valid;
  logic [3:0]  r_cmd_bank;
  logic [17:0] r_cmd_row;
  logic [9:0]  r_cmd_col;
  logic [2:0]  r_mr_sel;
  logic [17:0] r_mr_data;
  logic [4:0]  r_cl;
  logic [4:0]  r_cwl;
  logic        r_bl8;
  logic [15:0] r_bank_open;
  logic [31:0] r_rd_sr;
  logic [31:0] r_wr_sr;
  logic [17:0] r_row_tbl [16];

  assign w_bank   = {bus.bg_addr, bus.ba_addr};
  assign w_mr_sel = {bus.bg_addr[0], bus.ba_addr};
  assign w_addr   = {bus.A17, bus.RAS_n_A16, bus.CAS_n_A15, bus.WE_n_A14,
                     bus.A13, bus.A12_BC_n, bus.A11, bus.A10_AP, bus.A9_A0};

  // Pin-level command classification in JEDEC priority order
  always_comb begin
    w_cmd = C_NOP;
    if (bus.cs_n) begin
      w_cmd = C_DES;
    end else if (!bus.act_n) begin
      w_cmd = C_ACT;
    end else begin
      case ({bus.RAS_n_A16, bus.CAS_n_A15, bus.WE_n_A14})
        3'b000:  w_cmd = C_MRS;
        3'b001:  w_cmd = C_REF;
        3'b010:  w_cmd = bus.A10_AP ? C_PREA : C_PRE;
        3'b011:  w_cmd = C_RFU;
        3'b100:  w_cmd = bus.A10_AP ? C_WRA : C_WR;
        3'b101:  w_cmd = bus.A10_AP ? C_RDA : C_RD;
        3'b110:  w_cmd = C_ZQC;
        default: w_cmd = C_NOP;
      endcase
    end
  end

  assign w_is_rd = (w_cmd == C_RD) || (w_cmd == C_RDA);
  assign w_is_wr = (w_cmd == C_WR) || (w_cmd == C_WRA);

  // Burst masks use the latency/BL currently registered, so an MRS on the
  // same edge only affects later commands. Bit j = enable after edge n+j.
  assign w_rd_mask = (r_bl8 ? 32'h0000_000F : 32'h0000_0003) << r_cl;
  assign w_wr_mask = (r_bl8 ? 32'h0000_000F : 32'h0000_0003) << r_cwl;

  // Next bank-open vector and mode-register derived latencies
  always_comb begin
    w_bank_open_nxt = r_bank_open;
    w_cl_nxt        = r_cl;
    w_cwl_nxt       = r_cwl;
    w_bl8_nxt       = r_bl8;
    case (w_cmd)
      C_ACT:               w_bank_open_nxt[w_bank] = 1'b1;
      C_PRE, C_RDA, C_WRA: w_bank_open_nxt[w_bank] = 1'b0;
      C_PREA:              w_bank_open_nxt = '0;
      C_MRS: begin
        if (w_mr_sel == 3'd0) begin
          w_cl_nxt  = (w_addr[6:3] < 4'd4) ? (5'd9 + 5'(w_addr[6:3])) : 5'd9;
          w_bl8_nxt = (w_addr[1:0] != 2'b10);
        end else if (w_mr_sel == 3'd2) begin
          w_cwl_nxt = ((w_addr[5:3] == 3'd0) || (w_addr[5:3] == 3'd2))
                      ? (5'd9 + 5'(w_addr[5:3])) : 5'd9;
        end
      end
      default: ;
    endcase
  end

  // Registered command outputs, bank state, mode registers, data windows
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= C_DES;
      r_cmd_bank  <= '0;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
      r_mr_sel    <= '0;
      r_mr_data   <= '0;
      r_cl        <= CL_RST;
      r_cwl       <= CWL_RST;
      r_bl8       <= BL8_RST;
      r_bank_open <= '0;
      r_rd_sr     <= '0;
      r_wr_sr     <= '0;
    end else begin
      r_cmd_valid <= (w_cmd != C_DES) && (w_cmd != C_NOP);
      r_cmd_code  <= w_cmd;
      r_cmd_bank  <= w_bank;
      r_cmd_row   <= w_addr;
      r_cmd_col   <= bus.A9_A0;
      if (w_cmd == C_MRS) begin
        r_mr_sel  <= w_mr_sel;
        r_mr_data <= w_addr;
      end
      r_cl        <= w_cl_nxt;
      r_cwl       <= w_cwl_nxt;
      r_bl8       <= w_bl8_nxt;
      r_bank_open <= w_bank_open_nxt;
      r_rd_sr     <= (r_rd_sr >> 1) | (w_is_rd ? w_rd_mask : 32'd0);
      r_wr_sr     <= (r_wr_sr >> 1) | (w_is_wr ? w_wr_mask : 32'd0);
    end
  end

  // Row table: not reset, validity comes from bank_open
  always_ff @(posedge CK_t) begin
    if (w_cmd == C_ACT) r_row_tbl[w_bank] <= w_addr;
  end

`ifdef CMD_CHECK_EN
  logic       w_err;
  logic       r_err_pulse;
  logic [7:0] r_err_count;

  assign w_err = ((w_cmd == C_ACT) && r_bank_open[w_bank])
              || ((w_is_rd || w_is_wr) && !r_bank_open[w_bank])
              || (((w_cmd == C_REF) || (w_cmd == C_MRS)) && (|r_bank_open))
              || (w_cmd == C_RFU);

  // Error pulse and saturating error counter
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign bus.err_pulse = r_err_pulse;
  assign bus.err_count = r_err_count;
`endif

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_code  = r_cmd_code;
  assign bus.cmd_bank  = r_cmd_bank;
  assign bus.cmd_row   = r_cmd_row;
  assign bus.cmd_col   = r_cmd_col;
  assign bus.mr_sel    = r_mr_sel;
  assign bus.mr_data   = r_mr_data;
  assign bus.cur_cl    = r_cl;
  assign bus.cur_cwl   = r_cwl;
  assign bus.cur_bl8   = r_bl8;
  assign bus.bank_open = r_bank_open;
  assign bus.rd_en     = r_rd_sr[0];
  assign bus.wr_en     = r_wr_sr[0];
  assign bus.cur_row   = r_row_tbl[r_cmd_bank];

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// tb_ddr_cmd_decoder: directed-vector bench for ddr_cmd_decoder.
// Error-checking expectations are compiled in when CMD_CHECK_EN is defined.
module tb_ddr_cmd_decoder;

  logic CK_t;
  logic reset_n;
  int   checks;
  int   failures;
  logic [0:0] exp_q[$];

  ddr_cmd_decoder_if bus ();

  ddr_cmd_decoder #(
    .CL_DEFAULT (11),
    .CWL_DEFAULT(9),
    .BL_DEFAULT (8)
  ) dut (
    .CK_t   (CK_t),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // clock / reset
  initial CK_t = 1'b0;
  always #5 CK_t = ~CK_t;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic cs, input logic act, input logic [17:0] a,
                       input logic [3:0] bank);
    bus.cs_n      = cs;
    bus.act_n     = act;
    bus.A17       = a[17];
    bus.RAS_n_A16 = a[16];
    bus.CAS_n_A15 = a[15];
    bus.WE_n_A14  = a[14];
    bus.A13       = a[13];
    bus.A12_BC_n  = a[12];
    bus.A11       = a[11];
    bus.A10_AP    = a[10];
    bus.A9_A0     = a[9:0];
    bus.bg_addr   = bank[3:2];
    bus.ba_addr   = bank[1:0];
  endtask

  function automatic logic [17:0] cas_addr(input logic [2:0] rcw,
                                           input logic a10,
                                           input logic [9:0] low);
    return {1'b0, rcw, 3'b000, a10, low};
  endfunction

  task automatic step();
    @(posedge CK_t);
    #1;
  endtask

  task automatic do_nop();
    drive(1'b0, 1'b1, cas_addr(3'b111, 1'b0, 10'd0), 4'd0);
    step();
  endtask
  task automatic do_act(input logic [3:0] bank, input logic [17:0] row);
    drive(1'b0, 1'b0, row, bank);
    step();
  endtask
  task automatic do_rd(input logic [3:0] bank, input logic ap, input logic [9:0] col);
    drive(1'b0, 1'b1, cas_addr(3'b101, ap, col), bank);
    step();
  endtask
  task automatic do_wr(input logic [3:0] bank, input logic ap, input logic [9:0] col);
    drive(1'b0, 1'b1, cas_addr(3'b100, ap, col), bank);
    step();
  endtask
  task automatic do_pre(input logic [3:0] bank, input logic all);
    drive(1'b0, 1'b1, cas_addr(3'b010, all, 10'd0), bank);
    step();
  endtask
  task automatic do_mrs(input logic [2:0] sel, input logic [17:0] op);
    drive(1'b0, 1'b1, {op[17], 3'b000, op[13:0]}, {1'b0, sel});
    step();
  endtask
  task automatic do_raw(input logic [2:0] rcw);
    drive(1'b0, 1'b1, cas_addr(rcw, 1'b0, 10'd0), 4'd0);
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    drive(1'b0, 1'b1, cas_addr(3'b111, 1'b0, 10'd0), 4'd0);
    step();
    step();

    // reset state
    check_eq("rst_valid", bus.cmd_valid, 0);
    check_eq("rst_code",  bus.cmd_code, 0);
    check_eq("rst_cl",    bus.cur_cl, 11);
    check_eq("rst_cwl",   bus.cur_cwl, 9);
    check_eq("rst_bl8",   bus.cur_bl8, 1);
    check_eq("rst_open",  bus.bank_open, 0);
    check_eq("rst_rd_en", bus.rd_en, 0);
    check_eq("rst_wr_en", bus.wr_en, 0);
`ifdef CMD_CHECK_EN
    check_eq("rst_err_cnt", bus.err_count, 0);
`endif
    reset_n = 1'b1;

    do_nop();
    check_eq("nop_code",  bus.cmd_code, 1);
    check_eq("nop_valid", bus.cmd_valid, 0);

    // ACT bank 5 row 0x1234
    do_act(4'd5, 18'h01234);
    check_eq("act_code",  bus.cmd_code, 2);
    check_eq("act_valid", bus.cmd_valid, 1);
    check_eq("act_bank",  bus.cmd_bank, 5);
    check_eq("act_row",   bus.cmd_row, 32'h1234);
    check_eq("act_open",  bus.bank_open, 16'h0020);
    check_eq("act_tbl",   bus.cur_row, 32'h1234);
`ifdef CMD_CHECK_EN
    check_eq("act_err", bus.err_pulse, 0);
`endif

    do_pre(4'd5, 1'b0);
    check_eq("pre_code", bus.cmd_code, 7);
    check_eq("pre_open", bus.bank_open, 0);

    // mode register writes
    do_mrs(3'd0, 18'h00010);
    check_eq("mr0a_code", bus.cmd_code, 10);
    check_eq("mr0a_sel",  bus.mr_sel, 0);
    check_eq("mr0a_data", bus.mr_data, 32'h10);
    check_eq("mr0a_cl",   bus.cur_cl, 11);
    check_eq("mr0a_bl8",  bus.cur_bl8, 1);
    do_mrs(3'd0, 18'h0000A);
    check_eq("mr0b_cl",  bus.cur_cl, 10);
    check_eq("mr0b_bl8", bus.cur_bl8, 0);
    do_mrs(3'd0, 18'h00028);
    check_eq("mr0c_cl",  bus.cur_cl, 9);
    check_eq("mr0c_bl8", bus.cur_bl8, 1);
    do_mrs(3'd2, 18'h00010);
    check_eq("mr2a_sel", bus.mr_sel, 2);
    check_eq("mr2a_cwl", bus.cur_cwl, 11);
    do_mrs(3'd2, 18'h00018);
    check_eq("mr2b_cwl", bus.cur_cwl, 9);
    do_mrs(3'd2, 18'h00010);
    check_eq("mr2c_cwl", bus.cur_cwl, 11);
    do_mrs(3'd0, 18'h0000A);
    do_mrs(3'd3, 18'h003FF);
    check_eq("mr3_sel",  bus.mr_sel, 3);
    check_eq("mr3_data", bus.mr_data, 32'h3FF);
    check_eq("mr3_cl",   bus.cur_cl, 10);

    // CL=10 BL4 read window: after edges n+10..n+11
    do_act(4'd3, 18'h00ABC);
    do_rd(4'd3, 1'b0, 10'h155);
    check_eq("rd_code",  bus.cmd_code, 3);
    check_eq("rd_col",   bus.cmd_col, 32'h155);
    check_eq("rd_en_n0", bus.rd_en, 0);
    for (int i = 1; i <= 14; i++) exp_q.push_back((i >= 10 && i <= 11) ? 1'b1 : 1'b0);
    while (exp_q.size() > 0) begin
      do_nop();
      check_eq("rd_win_cl10_bl4", bus.rd_en, exp_q.pop_front());
    end

    do_pre(4'd0, 1'b1);
    check_eq("prea1_code", bus.cmd_code, 8);
    check_eq("prea1_open", bus.bank_open, 0);
    do_mrs(3'd0, 18'h00010);
    check_eq("mr0d_cl",  bus.cur_cl, 11);
    check_eq("mr0d_bl8", bus.cur_bl8, 1);
    do_act(4'd3, 18'h00ABC);

    // two RDs 4 cycles apart, CL=11 BL8: rd_en high after edges n+11..n+18
    do_rd(4'd3, 1'b0, 10'h010);
    for (int i = 1; i <= 22; i++) exp_q.push_back((i >= 11 && i <= 18) ? 1'b1 : 1'b0);
    for (int i = 1; i <= 22; i++) begin
      if (i == 4) do_rd(4'd3, 1'b0, 10'h020);
      else        do_nop();
      check_eq("rd_win_b2b", bus.rd_en, exp_q.pop_front());
    end

    // WR with CWL=11 BL8: wr_en after edges m+11..m+14
    do_wr(4'd3, 1'b0, 10'h044);
    check_eq("wr_code", bus.cmd_code, 5);
    for (int i = 1; i <= 16; i++) exp_q.push_back((i >= 11 && i <= 14) ? 1'b1 : 1'b0);
    while (exp_q.size() > 0) begin
      do_nop();
      check_eq("wr_win_cwl11", bus.wr_en, exp_q.pop_front());
    end

    // WRA closes bank 3; following RD is to a closed bank
    do_wr(4'd3, 1'b1, 10'h000);
    check_eq("wra_code", bus.cmd_code, 6);
    check_eq("wra_open", bus.bank_open, 0);
    do_rd(4'd3, 1'b0, 10'h000);
`ifdef CMD_CHECK_EN
    check_eq("rd_closed_err", bus.err_pulse, 1);
    check_eq("rd_closed_cnt", bus.err_count, 1);
`endif

    // PREA with banks 0, 7, 15 open
    do_act(4'd0, 18'h00001);
    do_act(4'd7, 18'h00007);
    do_act(4'd15, 18'h3FFFF);
    check_eq("three_open", bus.bank_open, 16'h8081);
    check_eq("act15_row",  bus.cmd_row, 32'h3FFFF);
    do_pre(4'd0, 1'b1);
    check_eq("prea2_open", bus.bank_open, 0);
    do_act(4'd7, 18'h00077);
    check_eq("act7_open", bus.bank_open, 16'h0080);
`ifdef CMD_CHECK_EN
    check_eq("act7_err", bus.err_pulse, 0);
    check_eq("act7_cnt", bus.err_count, 1);
`endif

    // reset mid-burst
    do_rd(4'd7, 1'b0, 10'h000);
    for (int i = 1; i <= 11; i++) do_nop();
    check_eq("mid_rd_en", bus.rd_en, 1);
    reset_n = 1'b0;
    #1;
    check_eq("arst_rd_en", bus.rd_en, 0);
    check_eq("arst_cl",    bus.cur_cl, 11);
    check_eq("arst_open",  bus.bank_open, 0);
    check_eq("arst_code",  bus.cmd_code, 0);
`ifdef CMD_CHECK_EN
    check_eq("arst_cnt", bus.err_count, 0);
`endif
    step();
    reset_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      do_nop();
      check_eq("post_rst_rd_en", bus.rd_en, 0);
    end

    // remaining decode codes
    do_raw(3'b110);
    check_eq("zqc_code", bus.cmd_code, 11);
    do_raw(3'b001);
    check_eq("ref_code", bus.cmd_code, 9);
`ifdef CMD_CHECK_EN
    check_eq("ref_err", bus.err_pulse, 0);
`endif
    do_raw(3'b011);
    check_eq("rfu_code", bus.cmd_code, 15);
`ifdef CMD_CHECK_EN
    check_eq("rfu_err", bus.err_pulse, 1);
    check_eq("rfu_cnt", bus.err_count, 1);
`endif
    drive(1'b1, 1'b0, 18'h00000, 4'd9);
    step();
    check_eq("des_code",  bus.cmd_code, 0);
    check_eq("des_valid", bus.cmd_valid, 0);
`ifdef CMD_CHECK_EN
    check_eq("des_err", bus.err_pulse, 0);
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_decoder.md
# ddr_cmd_decoder

Memory-side decoder for the DDR4 command/address pin bus driven by the controller's command generator. It samples the pins on every rising CK_t and classifies each cycle into a JEDEC command. It tracks the open/closed state and open row of all 16 banks, captures CL/CWL/BL from MRS writes, and generates read/write data-window enables. It sits in the memory model/testbench side of the DDR4 interface as the far end of the command bus.

## Interface
- CL_DEFAULT, 11: CAS latency used until an MR0 write.
- CWL_DEFAULT, 9: CAS write latency used until an MR2 write.
- BL_DEFAULT, 8: burst length used until an MR0 write; legal values 4 or 8.

Ports:
- CK_t in 1: command clock; all state updates on its rising edge.
- reset_n in 1: asynchronous, active-low reset.
- cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14 in 1 each: command pins.
- bg_addr in 2: bank group address.
- ba_addr in 2: bank address.
- A17, A13, A12_BC_n, A11, A10_AP in 1 each: address pins.
- A9_A0 in 10: address pins.
- cmd_valid out 1: high for one cycle when a non-DES, non-NOP command is decoded.
- cmd_code out 4: command code. 0 DES, 1 NOP, 2 ACT, 3 RD, 4 RDA, 5 WR, 6 WRA, 7 PRE, 8 PREA, 9 REF, 10 MRS, 11 ZQC, 15 RFU.
- cmd_bank out 4: {bg_addr, ba_addr} of the decoded command.
- cmd_row out 18: ACT row, formed as {A17, RAS_n_A16, CAS_n_A15, WE_n_A14, A13, A12_BC_n, A11, A10_AP, A9_A0}.
- cmd_col out 10: RD/WR column, taken from A9_A0.
- mr_sel out 3: {bg_addr[0], ba_addr} of the last MRS.
- mr_data out 18: MRS opcode, same bit packing as cmd_row.
- cur_cl, cur_cwl out 5 each: active latencies.
- cur_bl8 out 1: 1 = BL8, 0 = BL4.
- bank_open out 16: per-bank open flags, indexed {bg, ba}.
- rd_en out 1: read data window enable.
- wr_en out 1: write data window enable.
- err_pulse out 1: protocol error this cycle; present only when CMD_CHECK_EN is defined.
- err_count out 8: saturating error count; present only when CMD_CHECK_EN is defined.

## Operation
- Decode order:
  - cs_n=1 decodes as DES.
  - Else act_n=0 decodes as ACT.
  - Else {RAS_n_A16, CAS_n_A15, WE_n_A14}:
    - 000 MRS
    - 001 REF
    - 010 PRE if A10_AP=0, PREA if A10_AP=1
    - 011 RFU
    - 100 WR if A10_AP=0, WRA if A10_AP=1
    - 101 RD if A10_AP=0, RDA if A10_AP=1
    - 110 ZQC
    - 111 NOP
- Bank state:
  - ACT sets bank_open[bank] and stores cmd_row in a 16x18 row table.
  - PRE clears bank_open[bank].
  - PREA clears all 16 flags.
  - RDA and WRA clear bank_open[bank] in the same update as the command.
- MRS captures mr_sel and mr_data every time.
- MR0 (mr_sel=0):
  - CL = 9 + A[6:3] if A[6:3] < 4, else 9.
  - BL4 if A[1:0] = 2'b10, else BL8.
- MR2 (mr_sel=2): CWL = 9 + A[5:3] if A[5:3] is 0 or 2, else 9.
- All other mode registers are captured into mr_sel/mr_data only.
- Data windows use two 32-bit shift registers, one for read and one for write.
  - An RD/RDA sampled at edge n drives rd_en high after edges n+CL through n+CL+BL/2-1.
  - WR/WRA does the same on wr_en, using CWL.
  - Overlapping windows OR together, so back-to-back bursts give a continuous enable.
  - A burst uses the latency and BL values in effect on the edge its command is sampled. An MRS on that same edge takes effect from the next command.

## Timing
- All outputs are registered. A command sampled at edge n appears on cmd_* and cmd_valid after edge n, for one cycle.
- bank_open and cur_* update after the same edge n.
- Reset (asynchronous, any time, including mid-burst) clears:
  - cmd_valid, rd_en, wr_en, err_pulse and err_count to 0.
  - cmd_code to 0 (DES); all other cmd_* outputs, mr_sel and mr_data to 0.
  - bank_open to 0 and both shift registers.
- Reset loads cur_cl=CL_DEFAULT, cur_cwl=CWL_DEFAULT and cur_bl8=(BL_DEFAULT==8).
- No burst in flight survives reset.
- The row table is not reset; only bank_open qualifies it.

## Configuration
- CMD_CHECK_EN defined: err_pulse is asserted one cycle after any of these is sampled:
  - ACT to an already-open bank.
  - RD/RDA/WR/WRA to a closed bank.
  - REF or MRS while any bank is open.
  - RFU.
- With CMD_CHECK_EN, err_count increments on each err_pulse and saturates at 255.
- Erroneous commands still update bank state exactly as in Operation.
- CMD_CHECK_EN undefined: the checking logic, err_pulse and err_count are absent. Decode and bank tracking are identical.

## Test plan
- Reset then ACT to bank 5, row 0x1234 -> cmd_code=2, cmd_bank=5, cmd_row=0x1234, bank_open[5]=1.
- MRS mr_sel=0, A[6:3]=2, A[1:0]=0, then RD at edge 20 -> cur_cl=11, cur_bl8=1; rd_en high after edges 31..34 only.
- Two RDs 4 cycles apart with CL=11, BL8 -> rd_en continuously high for 8 cycles.
- WRA to open bank 3 -> cmd_code=6, bank_open[3]=0. A following RD to bank 3 -> err_pulse=1, err_count=1 (CMD_CHECK_EN).
- PREA with banks 0, 7 and 15 open -> bank_open=0; following ACT to bank 7 -> no error.
- Assert reset_n=0 mid-burst at rd_en=1 -> rd_en=0 immediately; cur_cl=11, bank_open=0.
